fp_fwd_scoreboard: RTL and testbench

Parametrised FP operand forwarding and hazard unit for the RV32IF pipeline, sitting between ID operand read and the ID/EX register. It selects each of NUM_SRC source operands from regfile, EX, MEM or WB results, and adds a per-register busy scoreboard so long-latency FP ops (FDIV/FSQRT) may issue and retire out of band without a blanket pipeline freeze. Stall is raised only for true RAW/WAW dependences or when the long-latency unit is out of tracking slots.

---
 rtl/fp_fwd_scoreboard.sv | 120 ++++++++++++
 tb/tb_fp_fwd_scoreboard.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_fwd_scoreboard.sv
// FP operand forwarding and long-latency busy scoreboard for the RV32IF ID stage.
// Define FPFWD_WB_FWD_EN to add WB as a forwarding source (sel 11); otherwise the regfile must be write-first.
module fp_fwd_scoreboard #(
    parameter int NUM_SRC  = 3,
    parameter int XLEN     = 32,
    parameter int MAX_LONG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic                    id_is_fp,
    input  logic [NUM_SRC*5-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [4:0]              id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_long_lat,
    input  logic [NUM_SRC*XLEN-1:0] rf_rdata,
    input  logic [4:0]              rd_ex,
    input  logic [4:0]              rd_mem,
    input  logic [4:0]              rd_wb,
    input  logic                    reg_write_ex,
    input  logic                    reg_write_mem,
    input  logic                    reg_write_wb,
    input  logic [XLEN-1:0]         result_ex,
    input  logic [XLEN-1:0]         result_mem,
    input  logic [XLEN-1:0]         result_wb,
    input  logic                    ex_result_ready,
    input  logic                    lu_done,
    input  logic [4:0]              lu_rd,
    output logic [NUM_SRC*2-1:0]    fwd_sel,
    output logic [NUM_SRC*XLEN-1:0] fwd_data,
    output logic                    stall,
    output logic [31:0]             busy,
    output logic [4:0]              long_cnt,
    output logic                    sb_err
);

    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic        id_active;
    logic        src_stall;
    logic        waw_hit;
    logic        long_full;
    logic        done_hit;
    logic        issue;
    logic [4:0]  rs;
    logic [31:0] busy_next;
    logic [4:0]  cnt_next;

`ifndef FPFWD_WB_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{rd_wb, reg_write_wb, result_wb};
`endif

    assign id_active = id_valid && id_is_fp;
    assign done_hit  = lu_done && busy[lu_rd];

    // A source needing an EX result that is not ready yet stalls and keeps the regfile selection.
    always_comb begin
        fwd_sel   = '0;
        fwd_data  = rf_rdata;
        src_stall = 1'b0;
        rs        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rs = id_rs[5*k +: 5];
            if (id_active && id_rs_used[k] && rs != 5'd0) begin
                if (busy[rs])
                    src_stall = 1'b1;
                if (reg_write_ex && rd_ex == rs) begin
                    if (ex_result_ready) begin
                        fwd_sel[2*k +: 2]     = SEL_EX;
                        fwd_data[XLEN*k +: XLEN] = result_ex;
                    end else begin
                        src_stall = 1'b1;
                    end
                end else if (reg_write_mem && rd_mem == rs) begin
                    fwd_sel[2*k +: 2]     = SEL_MEM;
                    fwd_data[XLEN*k +: XLEN] = result_mem;
                end
`ifdef FPFWD_WB_FWD_EN
                else if (reg_write_wb && rd_wb == rs) begin
                    fwd_sel[2*k +: 2]     = 2'b11;
                    fwd_data[XLEN*k +: XLEN] = result_wb;
                end
`endif
            end
        end
    end

    // A slot retiring this cycle frees room for a new long op in the same cycle.
    assign long_full = (long_cnt == 5'(MAX_LONG)) && !done_hit;
    assign waw_hit   = id_reg_write && busy[id_rd];
    assign stall     = id_active && (src_stall || waw_hit || (id_long_lat && long_full));
    assign issue     = id_active && !stall && id_long_lat && id_reg_write && (id_rd != 5'd0);

    always_comb begin
        busy_next = busy;
        if (done_hit)
            busy_next[lu_rd] = 1'b0;
        if (issue)
            busy_next[id_rd] = 1'b1;
        busy_next[0] = 1'b0;
        cnt_next = long_cnt + {4'd0, issue} - {4'd0, done_hit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            long_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy     <= busy_next;
            long_cnt <= cnt_next;
            if (lu_done && !busy[lu_rd])
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_fwd_scoreboard.sv
// Self-checking bench for fp_fwd_scoreboard: directed scenarios plus randomized traffic
// checked against a register-set model of the scoreboard and a stage-table forwarding model.
module tb_fp_fwd_scoreboard;

    localparam int NS = 3;
    localparam int XL = 32;
    localparam int ML = 2;
`ifdef FPFWD_WB_FWD_EN
    localparam int N_STAGES = 3;
`else
    localparam int N_STAGES = 2;
`endif

    localparam logic [NS*XL-1:0] RF_CONST = {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
    localparam logic [XL-1:0] EX_CONST  = 32'hE0E0E0E0;
    localparam logic [XL-1:0] MEM_CONST = 32'h3E303E30;
    localparam logic [XL-1:0] WB_CONST  = 32'h4B4B4B4B;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid, id_is_fp, id_reg_write, id_long_lat;
    logic [NS*5-1:0]  id_rs;
    logic [NS-1:0]    id_rs_used;
    logic [4:0]       id_rd;
    logic [NS*XL-1:0] rf_rdata;
    logic [4:0]       rd_ex, rd_mem, rd_wb;
    logic             reg_write_ex, reg_write_mem, reg_write_wb;
    logic [XL-1:0]    result_ex, result_mem, result_wb;
    logic             ex_result_ready, lu_done;
    logic [4:0]       lu_rd;
    logic [NS*2-1:0]  fwd_sel;
    logic [NS*XL-1:0] fwd_data;
    logic             stall;
    logic [31:0]      busy;
    logic [4:0]       long_cnt;
    logic             sb_err;

    int errors = 0;
    int checks = 0;

    fp_fwd_scoreboard #(.NUM_SRC(NS), .XLEN(XL), .MAX_LONG(ML)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_is_fp(id_is_fp), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_long_lat(id_long_lat),
        .rf_rdata(rf_rdata),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .result_ex(result_ex), .result_mem(result_mem), .result_wb(result_wb),
        .ex_result_ready(ex_result_ready), .lu_done(lu_done), .lu_rd(lu_rd),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall),
        .busy(busy), .long_cnt(long_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_is_fp = 1'b0; id_rs = '0; id_rs_used = '0;
        id_rd = '0; id_reg_write = 1'b0; id_long_lat = 1'b0;
        rf_rdata = RF_CONST;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        result_ex = EX_CONST; result_mem = MEM_CONST; result_wb = WB_CONST;
        ex_result_ready = 1'b1; lu_done = 1'b0; lu_rd = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
        checks++; if (long_cnt !== 5'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", long_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sb_err: got %b expected 0", sb_err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL idle_stall: got %b expected 0", stall); end
        checks++; if (fwd_sel !== 6'd0) begin errors++; $display("[TB] FAIL idle_sel: got %b expected 0", fwd_sel); end
        checks++; if (fwd_data !== RF_CONST) begin errors++; $display("[TB] FAIL idle_data: got %h expected %h", fwd_data, RF_CONST); end
    endtask

    task automatic test_ex_forward();
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1;
        id_rs = {5'd0, 5'd2, 5'd1}; id_rs_used = 3'b011; id_rd = 5'd3; id_reg_write = 1'b1;
        rd_ex = 5'd1; reg_write_ex = 1'b1; ex_result_ready = 1'b1;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'b01) begin errors++; $display("[TB] FAIL ex_sel0: got %b expected 01", fwd_sel[1:0]); end
        checks++; if (fwd_data[31:0] !== EX_CONST) begin errors++; $display("[TB] FAIL ex_data0: got %h expected %h", fwd_data[31:0], EX_CONST); end
        checks++; if (fwd_sel[3:2] !== 2'b00) begin errors++; $display("[TB] FAIL ex_sel1: got %b expected 00", fwd_sel[3:2]); end
        checks++; if (fwd_data[63:32] !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL ex_data1: got %h expected aaaa0001", fwd_data[63:32]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ex_stall: got %b expected 0", stall); end
        id_is_fp = 1'b0;
        #1;
        checks++; if (fwd_sel !== 6'd0) begin errors++; $display("[TB] FAIL nonfp_sel: got %b expected 0", fwd_sel); end
        checks++; if (fwd_data !== RF_CONST) begin errors++; $display("[TB] FAIL nonfp_data: got %h expected %h", fwd_data, RF_CONST); end
    endtask

    task automatic test_load_use();
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1;
        id_rs = {5'd0, 5'd0, 5'd1}; id_rs_used = 3'b001; id_rd = 5'd4; id_reg_write = 1'b1;
        rd_ex = 5'd1; reg_write_ex = 1'b1; ex_result_ready = 1'b0;
        rd_mem = 5'd1; reg_write_mem = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL load_stall: got %b expected 1", stall); end
        checks++; if (fwd_sel[1:0] !== 2'b00) begin errors++; $display("[TB] FAIL load_sel: got %b expected 00", fwd_sel[1:0]); end
        id_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL load_invalid_stall: got %b expected 0", stall); end
        id_valid = 1'b1;
        tick();
        rd_ex = 5'd0; reg_write_ex = 1'b0; ex_result_ready = 1'b1;
        #1;
        checks++; if (fwd_sel[1:0] !== 2'b10) begin errors++; $display("[TB] FAIL load_mem_sel: got %b expected 10", fwd_sel[1:0]); end
        checks++; if (fwd_data[31:0] !== MEM_CONST) begin errors++; $display("[TB] FAIL load_mem_data: got %h expected %h", fwd_data[31:0], MEM_CONST); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL load_mem_stall: got %b expected 0", stall); end
    endtask

    task automatic test_fmadd_priority();
        logic [5:0]  exp_sel;
        logic [95:0] exp_data;
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1;
        id_rs = {5'd0, 5'd4, 5'd4}; id_rs_used = 3'b111; id_rd = 5'd8; id_reg_write = 1'b1;
        rd_ex = 5'd4; reg_write_ex = 1'b1;
        rd_mem = 5'd4; reg_write_mem = 1'b1;
        rd_wb = 5'd4; reg_write_wb = 1'b1;
        #1;
        checks++; if (fwd_sel !== 6'b00_01_01) begin errors++; $display("[TB] FAIL fmadd_sel: got %b expected 000101", fwd_sel); end
        exp_data = {32'hAAAA0002, EX_CONST, EX_CONST};
        checks++; if (fwd_data !== exp_data) begin errors++; $display("[TB] FAIL fmadd_data: got %h expected %h", fwd_data, exp_data); end
        rd_ex = 5'd9;
        #1;
        checks++; if (fwd_sel !== 6'b00_10_10) begin errors++; $display("[TB] FAIL fmadd_mem_sel: got %b expected 001010", fwd_sel); end
        rd_mem = 5'd9;
        #1;
`ifdef FPFWD_WB_FWD_EN
        exp_sel = 6'b00_11_11;
        exp_data = {32'hAAAA0002, WB_CONST, WB_CONST};
`else
        exp_sel = 6'b00_00_00;
        exp_data = RF_CONST;
`endif
        checks++; if (fwd_sel !== exp_sel) begin errors++; $display("[TB] FAIL fmadd_wb_sel: got %b expected %b", fwd_sel, exp_sel); end
        checks++; if (fwd_data !== exp_data) begin errors++; $display("[TB] FAIL fmadd_wb_data: got %h expected %h", fwd_data, exp_data); end
    endtask

    task automatic test_long_raw();
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1;
        id_rs = {5'd0, 5'd2, 5'd1}; id_rs_used = 3'b011; id_rd = 5'd5;
        id_reg_write = 1'b1; id_long_lat = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL fdiv_issue_stall: got %b expected 0", stall); end
        tick();
        id_rs = {5'd0, 5'd7, 5'd5}; id_rd = 5'd6; id_long_lat = 1'b0;
        #1;
        checks++; if (busy[5] !== 1'b1) begin errors++; $display("[TB] FAIL fdiv_busy_set: got %b expected 1", busy[5]); end
        checks++; if (long_cnt !== 5'd1) begin errors++; $display("[TB] FAIL fdiv_cnt_one: got %0d expected 1", long_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall: got %b expected 1", stall); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall_hold: got %b expected 1", stall); end
        lu_done = 1'b1; lu_rd = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall_done_cycle: got %b expected 1", stall); end
        tick();
        lu_done = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL raw_release: got %b expected 0", stall); end
        checks++; if (busy[5] !== 1'b0) begin errors++; $display("[TB] FAIL fdiv_busy_clear: got %b expected 0", busy[5]); end
        checks++; if (long_cnt !== 5'd0) begin errors++; $display("[TB] FAIL fdiv_cnt_zero: got %0d expected 0", long_cnt); end
    endtask

    task automatic test_long_full();
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1; id_reg_write = 1'b1; id_long_lat = 1'b1;
        id_rd = 5'd1;
        tick();
        id_rd = 5'd2;
        tick();
        id_rd = 5'd3;
        #1;
        checks++; if (long_cnt !== 5'd2) begin errors++; $display("[TB] FAIL full_cnt: got %0d expected 2", long_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_stall: got %b expected 1", stall); end
        tick();
        checks++; if (busy !== 32'h6) begin errors++; $display("[TB] FAIL full_hold_busy: got %h expected 6", busy); end
        lu_done = 1'b1; lu_rd = 5'd1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL full_release_stall: got %b expected 0", stall); end
        tick();
        id_valid = 1'b0; lu_done = 1'b0;
        #1;
        checks++; if (long_cnt !== 5'd2) begin errors++; $display("[TB] FAIL full_swap_cnt: got %0d expected 2", long_cnt); end
        checks++; if (busy !== 32'hC) begin errors++; $display("[TB] FAIL full_swap_busy: got %h expected c", busy); end
        lu_done = 1'b1; lu_rd = 5'd2;
        tick();
        lu_rd = 5'd3;
        tick();
        lu_done = 1'b0;
        #1;
        checks++; if (long_cnt !== 5'd0) begin errors++; $display("[TB] FAIL full_drain_cnt: got %0d expected 0", long_cnt); end
    endtask

    task automatic test_sb_err();
        tick();
        idle();
        id_valid = 1'b1; id_is_fp = 1'b1; id_reg_write = 1'b1; id_long_lat = 1'b1; id_rd = 5'd7;
        tick();
        idle();
        lu_done = 1'b1; lu_rd = 5'd9;
        #1;
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL sberr_before_edge: got %b expected 0", sb_err); end
        tick();
        lu_done = 1'b0;
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL sberr_set: got %b expected 1", sb_err); end
        checks++; if (busy !== 32'h80) begin errors++; $display("[TB] FAIL sberr_busy_kept: got %h expected 80", busy); end
        checks++; if (long_cnt !== 5'd1) begin errors++; $display("[TB] FAIL sberr_cnt_kept: got %0d expected 1", long_cnt); end
        tick();
        tick();
        checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL sberr_sticky: got %b expected 1", sb_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL midrst_busy: got %h expected 0", busy); end
        checks++; if (long_cnt !== 5'd0) begin errors++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", long_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sberr: got %b expected 0", sb_err); end
        lu_done = 1'b1; lu_rd = 5'd7;
        tick();
        lu_done = 1'b0;
        #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL late_done_sberr: got %b expected 1", sb_err); end
        checks++; if (long_cnt !== 5'd0) begin errors++; $display("[TB] FAIL late_done_cnt: got %0d expected 0", long_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: busy registers held as a set, in-flight count is simply its size.
    task automatic test_random();
        logic [31:0]  m_busy;
        logic         m_err;
        logic [4:0]   st_rd [3];
        logic         st_we [3];
        logic [XL-1:0] st_res [3];
        logic [1:0]   st_code [3];
        logic [5:0]   exp_sel;
        logic [95:0]  exp_data;
        logic         exp_stall, active, frees_slot, will_issue;
        logic [4:0]   rs;
        int           q[$];
        idle();
        m_busy = '0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_is_fp = ($urandom_range(0, 5) != 0);
            for (int k = 0; k < NS; k++) id_rs[5*k +: 5] = 5'($urandom_range(0, 7));
            id_rs_used = 3'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_long_lat = ($urandom_range(0, 2) == 0);
            rf_rdata = {$urandom, $urandom, $urandom};
            rd_ex = 5'($urandom_range(0, 7));  reg_write_ex = 1'($urandom_range(0, 1));
            rd_mem = 5'($urandom_range(0, 7)); reg_write_mem = 1'($urandom_range(0, 1));
            rd_wb = 5'($urandom_range(0, 7));  reg_write_wb = 1'($urandom_range(0, 1));
            result_ex = $urandom; result_mem = $urandom; result_wb = $urandom;
            ex_result_ready = ($urandom_range(0, 3) != 0);
            q.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
            lu_done = 1'b0;
            lu_rd = 5'($urandom_range(0, 31));
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                lu_done = 1'b1;
                lu_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            end
            #1;
            st_rd[0] = rd_ex;  st_we[0] = reg_write_ex;  st_res[0] = result_ex;  st_code[0] = 2'b01;
            st_rd[1] = rd_mem; st_we[1] = reg_write_mem; st_res[1] = result_mem; st_code[1] = 2'b10;
            st_rd[2] = rd_wb;  st_we[2] = reg_write_wb;  st_res[2] = result_wb;  st_code[2] = 2'b11;
            active = id_valid && id_is_fp;
            exp_sel = '0;
            exp_data = rf_rdata;
            exp_stall = 1'b0;
            for (int k = 0; k < NS; k++) begin
                rs = id_rs[5*k +: 5];
                if (active && id_rs_used[k] && rs != 0) begin
                    if (m_busy[rs]) exp_stall = 1'b1;
                    for (int s = 0; s < N_STAGES; s++) begin
                        if (st_we[s] && st_rd[s] == rs) begin
                            if (s == 0 && !ex_result_ready) begin
                                exp_stall = 1'b1;
                            end else begin
                                exp_sel[2*k +: 2] = st_code[s];
                                exp_data[XL*k +: XL] = st_res[s];
                            end
                            break;
                        end
                    end
                end
            end
            frees_slot = lu_done && m_busy[lu_rd];
            if (active && id_reg_write && m_busy[id_rd]) exp_stall = 1'b1;
            if (active && id_long_lat && $countones(m_busy) == ML && !frees_slot) exp_stall = 1'b1;
            checks++; if (fwd_sel !== exp_sel) begin errors++; $display("[TB] FAIL rnd_sel cyc %0d: got %b expected %b", cyc, fwd_sel, exp_sel); end
            checks++; if (fwd_data !== exp_data) begin errors++; $display("[TB] FAIL rnd_data cyc %0d: got %h expected %h", cyc, fwd_data, exp_data); end
            checks++; if (stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall cyc %0d: got %b expected %b", cyc, stall, exp_stall); end
            checks++; if (busy !== m_busy) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d: got %h expected %h", cyc, busy, m_busy); end
            checks++; if (long_cnt !== 5'($countones(m_busy))) begin errors++; $display("[TB] FAIL rnd_cnt cyc %0d: got %0d expected %0d", cyc, long_cnt, $countones(m_busy)); end
            checks++; if (sb_err !== m_err) begin errors++; $display("[TB] FAIL rnd_sberr cyc %0d: got %b expected %b", cyc, sb_err, m_err); end
            will_issue = active && !exp_stall && id_long_lat && id_reg_write && id_rd != 0;
            if (lu_done && !m_busy[lu_rd]) m_err = 1'b1;
            if (frees_slot) m_busy[lu_rd] = 1'b0;
            if (will_issue) m_busy[id_rd] = 1'b1;
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_fmadd_priority();
        test_long_raw();
        test_long_full();
        test_sb_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
